// File: rtl/matmul_mem_arbiter_if.sv
// +--------------------------------------------------------------------+
// | matmul_mem_arbiter_if: requester/memory bus bundle. Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

interface matmul_mem_arbiter_if #(
  parameter int NREQ    = 2,
  parameter int DATA_BW = `TYPE_BW
);
  logic [2*NREQ-1:0]       req_op;
  logic [32*NREQ-1:0]      req_addr;
  logic [DATA_BW*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]         req_opdone;
  logic [DATA_BW-1:0]      req_rdata;
  logic [1:0]              mem_operation;
  logic [31:0]             mem_addr;
  logic [DATA_BW-1:0]      mem_wdata;
  logic                    mem_opdone;
  logic [DATA_BW-1:0]      mem_rdata;

  // master: the arbiter; slave: requesters plus memory model
  modport master (
    input  req_op, req_addr, req_wdata, mem_opdone, mem_rdata,
    output req_opdone, req_rdata, mem_operation, mem_addr, mem_wdata
  );
  modport slave (
    output req_op, req_addr, req_wdata, mem_opdone, mem_rdata,
    input  req_opdone, req_rdata, mem_operation, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/matmul_mem_arbiter.sv
// +--------------------------------------------------------------------+
// | matmul_mem_arbiter: round-robin shared-memory arbiter. Rev 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module matmul_mem_arbiter #(
  parameter int NREQ     = 2,
  parameter int DATA_BW  = `TYPE_BW,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  matmul_mem_arbiter_if.master  bus,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic                  err_spurious
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [1:0]  owner, owner_n;
  logic [1:0]  last_owner, last_owner_n;
  logic [7:0]  hold_cnt, hold_n, hold_inc;
  logic [3:0]  pend4;
  logic [1:0]  rr_pick;
  logic        rr_found;
  logic [1:0]  own_raw, own_op;
  logic        others_pending;
  logic        done_fwd;
  logic        spurious;

  // 10 is treated as no-op, so bit 0 alone marks a pending request
  generate
    for (genvar i = 0; i < 4; i++) begin : g_pend
      if (i < NREQ) begin : g_live
        assign pend4[i] = bus.req_op[2*i];
      end else begin : g_pad
        assign pend4[i] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    rr_pick  = last_owner;
    rr_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [1:0] cand;
      cand = 2'((int'(last_owner) + k) % NREQ);
      if (!rr_found && pend4[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  assign own_raw        = bus.req_op[2*int'(owner) +: 2];
  assign own_op         = own_raw[0] ? own_raw : 2'b00;
  assign others_pending = |(pend4 & ~(4'b0001 << owner));
  assign hold_inc       = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;

  always_comb begin
    bus.mem_operation = 2'b00;
    bus.mem_addr      = 32'd0;
    bus.mem_wdata     = {DATA_BW{1'b0}};
    if (state == GRANT) begin
      bus.mem_operation = own_op;
      bus.mem_addr      = bus.req_addr[32*int'(owner) +: 32];
      bus.mem_wdata     = bus.req_wdata[DATA_BW*int'(owner) +: DATA_BW];
    end
  end

  // completions only count when a real operation is on the bus
  assign done_fwd       = bus.mem_opdone && (bus.mem_operation != 2'b00);
  assign spurious       = bus.mem_opdone && (bus.mem_operation == 2'b00);
  assign bus.req_opdone = NREQ'(done_fwd) << owner;
  assign bus.req_rdata  = bus.mem_rdata;
  assign busy           = (state == GRANT);
  assign grant_id       = owner;

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    hold_n       = hold_cnt;
    case (state)
      IDLE: begin
        if (rr_found) begin
          owner_n = rr_pick;
          hold_n  = 8'd0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (done_fwd) hold_n = hold_inc;
        if (own_op == 2'b00) begin
          last_owner_n = owner;
          state_n      = IDLE;
        end else if ((int'(hold_n) >= MAX_HOLD) && others_pending) begin
          last_owner_n = owner;
          state_n      = SWITCH;
        end
      end
      SWITCH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= 2'd0;
      last_owner   <= 2'(NREQ - 1);
      hold_cnt     <= 8'd0;
      err_spurious <= 1'b0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      hold_cnt   <= hold_n;
      if (spurious) err_spurious <= 1'b1;
    end
  end

endmodule

`default_nettype wire
